// File: rtl/data_memory_pipe.sv
// Word-addressed data RAM for the MEM stage, with a reset-driven init sequencer and a bypass path.
// Latency: a response appears RD_LAT cycles after its accept edge; back-to-back requests are fully pipelined.
// Backpressure: req_ready is low only while INIT runs; responses cannot be stalled.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake; a request is accepted when both are high at a clock edge
//   memwrite, memread          write writeData to / read from mem[address[ADDR_W-1:0]]
//   memtoreg                   0: the response returns the address (bypass); 1: normal memory response
//   address, writeData         word address (or bypass value), and the write data
//   inj_par_err                store inverted parity on this write (parity build only)
//   rsp_valid, readData        one-cycle result pulse; readData holds the last result between pulses
//   parity_err                 stored parity disagrees with the word read; valid with rsp_valid
//
// Optional feature: define DMEM_PARITY_EN to store one even-parity bit per word.
module data_memory_pipe #(
    parameter int DATA_W    = 20,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int RD_LAT    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              inj_par_err,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] readData,
    output logic              parity_err
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(DEPTH - 1);

    state_t             state_q;
    state_t             state_d;
    logic               init_we;
    logic [ADDR_W-1:0]  init_cnt;
    logic [DATA_W-1:0]  init_val;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  idx;
    logic               in_range;
    logic               accept;
    logic               wr_en;
    logic               rsp_gen;
    logic [DATA_W-1:0]  rsp_dat;
    logic               rsp_perr;

    // Response pipeline: stage 0 is loaded at the accept edge; the last stage drives the outputs.
    logic               vld_q  [RD_LAT];
    logic [DATA_W-1:0]  dat_q  [RD_LAT];
    logic               perr_q [RD_LAT];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        init_we   = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (init_we && (init_cnt != INIT_LAST)) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign init_val = (INIT_MODE == 1) ? DATA_W'(init_cnt) : '0;

    // ---------------------------------------------------------------- request decode
    // Upper address bits are ignored for indexing but still returned on the bypass path.
    assign idx      = address[ADDR_W-1:0];
    assign in_range = (int'(idx) < DEPTH);
    assign accept   = req_valid & req_ready;
    assign wr_en    = accept & memwrite & in_range;
    assign rsp_gen  = accept & (~memtoreg | memread);

    // Bypass wins over memread; out-of-range reads return zero.
    always_comb begin
        rsp_dat = '0;
        if (!memtoreg) begin
            rsp_dat = address;
        end else if (in_range) begin
            rsp_dat = mem[idx];
        end
    end

    // ---------------------------------------------------------------- storage
    // Not reset: INIT rewrites every word after each reset. The read above samples
    // the array before this write lands, so a same-request write+read returns old data.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_cnt] <= init_val;
        end else if (wr_en) begin
            mem[idx] <= writeData;
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (init_we) begin
            par_mem[init_cnt] <= ^init_val;
        end else if (wr_en) begin
            par_mem[idx] <= (^writeData) ^ inj_par_err;
        end
    end

    // Only a real memory read can flag an error; bypass and out-of-range reads never do.
    assign rsp_perr = memtoreg & in_range & ((^mem[idx]) != par_mem[idx]);
`else
    logic unused_inj;
    assign unused_inj = inj_par_err;
    assign rsp_perr   = 1'b0;
`endif

    // ---------------------------------------------------------------- response pipeline
    // Data stages load only behind a valid, so the last stage holds the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                dat_q[i]  <= '0;
                perr_q[i] <= 1'b0;
            end
        end else begin
            vld_q[0] <= rsp_gen;
            if (rsp_gen) begin
                dat_q[0]  <= rsp_dat;
                perr_q[0] <= rsp_perr;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i]  <= dat_q[i-1];
                    perr_q[i] <= perr_q[i-1];
                end
            end
        end
    end

    assign rsp_valid  = vld_q[RD_LAT-1];
    assign readData   = dat_q[RD_LAT-1];
    assign parity_err = vld_q[RD_LAT-1] & perr_q[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_pipe.sv
// Self-checking bench for data_memory_pipe: two instances share one stimulus stream.
//   dut_a: DEPTH=32, RD_LAT=1      dut_b: DEPTH=24, RD_LAT=3      (both INIT_MODE=1)
module tb_data_memory_pipe;

`ifdef DMEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic        memtoreg = 1'b1;
    logic [19:0] address = '0;
    logic [19:0] writeData = '0;
    logic        inj_par_err = 1'b0;

    logic        req_ready_a, rsp_valid_a, parity_err_a;
    logic        req_ready_b, rsp_valid_b, parity_err_b;
    logic [19:0] readData_a, readData_b;

    always #5 clk = ~clk;

    data_memory_pipe #(.DATA_W(20), .DEPTH(32), .ADDR_W(5), .RD_LAT(LAT_A), .INIT_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
        .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg), .address(address),
        .writeData(writeData), .inj_par_err(inj_par_err), .rsp_valid(rsp_valid_a),
        .readData(readData_a), .parity_err(parity_err_a)
    );

    data_memory_pipe #(.DATA_W(20), .DEPTH(24), .ADDR_W(5), .RD_LAT(LAT_B), .INIT_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .memwrite(memwrite), .memread(memread), .memtoreg(memtoreg), .address(address),
        .writeData(writeData), .inj_par_err(inj_par_err), .rsp_valid(rsp_valid_b),
        .readData(readData_b), .parity_err(parity_err_b)
    );

    typedef struct {
        bit          vld, mw, mr, mt, inj;
        logic [19:0] addr, wd;
        bit          rsp;
        logic [19:0] ea, eb;
        bit          ep;
    } vec_t;

    typedef struct {
        logic [19:0] d;
        logic        p;
        int          due;
    } sb_t;

    sb_t  qa[$];
    sb_t  qb[$];
    vec_t vecs[21];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(bit vld, bit mw, bit mr, bit mt, bit inj, logic [19:0] addr,
                                logic [19:0] wd, bit rsp, logic [19:0] ea, logic [19:0] eb, bit ep);
        vec_t v;
        v.vld = vld; v.mw = mw; v.mr = mr; v.mt = mt; v.inj = inj;
        v.addr = addr; v.wd = wd; v.rsp = rsp; v.ea = ea; v.eb = eb; v.ep = ep;
        return v;
    endfunction

    // Apply one request right after a rising edge; it is accepted on the next edge.
    // A response is then due at the negedge of cycle cyc+LAT.
    task automatic drive(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        req_valid   = v.vld;
        memwrite    = v.mw;
        memread     = v.mr;
        memtoreg    = v.mt;
        address     = v.addr;
        writeData   = v.wd;
        inj_par_err = v.inj;
        if (v.vld && v.rsp && req_ready_a && req_ready_b) begin
            e.d = v.ea; e.p = v.ep; e.due = cyc + LAT_A; qa.push_back(e);
            e.d = v.eb; e.p = v.ep; e.due = cyc + LAT_B; qb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(mk(N, N, N, Y, N, 20'h0, 20'h0, N, 20'h0, 20'h0, N));
    endtask

    // Counts cycles with req_ready low after reset release; a request that would write
    // and bypass is held on the bus for the first 10 INIT cycles and must be ignored.
    task automatic measure_init(input string tag);
        int ca, cb, n;
        ca = 0; cb = 0; n = 0;
        req_valid = 1'b1; memwrite = 1'b1; memread = 1'b1; memtoreg = 1'b0;
        address = 20'h00004; writeData = 20'h0BEEF; inj_par_err = 1'b0;
        while (!(req_ready_a && req_ready_b) && n < 200) begin
            @(negedge clk);
            n++;
            if (!req_ready_a) ca++;
            if (!req_ready_b) cb++;
            if (n == 10) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk({tag, "_a_init_cycles"}, ca, 32);
        chk({tag, "_b_init_cycles"}, cb, 24);
    endtask

    // Scoreboard: every pulse must match the head of its queue in data, parity and cycle.
    always @(negedge clk) begin
        sb_t e;
        if (rsp_valid_a) begin
            if (qa.size() == 0) chk("a_unexpected_rsp", 32'(rsp_valid_a), 0);
            else begin
                e = qa.pop_front();
                chk("a_data", readData_a, e.d);
                chk("a_parity", parity_err_a, e.p);
                chk("a_latency", cyc, e.due);
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            chk("a_missing_rsp", 32'(rsp_valid_a), 1);
        end
        if (rsp_valid_b) begin
            if (qb.size() == 0) chk("b_unexpected_rsp", 32'(rsp_valid_b), 0);
            else begin
                e = qb.pop_front();
                chk("b_data", readData_b, e.d);
                chk("b_parity", parity_err_b, e.p);
                chk("b_latency", cyc, e.due);
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            chk("b_missing_rsp", 32'(rsp_valid_b), 1);
        end
    end

    initial begin
        //             vld mw mr mt inj addr       wdata      rsp exp_a      exp_b      par
        vecs[0]  = mk(Y, N, Y, Y, N, 20'h00007, 20'h00000, Y, 20'h00007, 20'h00007, N);
        vecs[1]  = mk(Y, N, Y, Y, N, 20'h00000, 20'h00000, Y, 20'h00000, 20'h00000, N);
        vecs[2]  = mk(Y, N, Y, Y, N, 20'h00001, 20'h00000, Y, 20'h00001, 20'h00001, N);
        vecs[3]  = mk(Y, N, Y, Y, N, 20'h00002, 20'h00000, Y, 20'h00002, 20'h00002, N);
        vecs[4]  = mk(Y, N, Y, Y, N, 20'h00003, 20'h00000, Y, 20'h00003, 20'h00003, N);
        vecs[5]  = mk(Y, N, Y, Y, N, 20'h00004, 20'h00000, Y, 20'h00004, 20'h00004, N);
        vecs[6]  = mk(Y, Y, N, Y, N, 20'h00003, 20'hABCDE, N, 20'h00000, 20'h00000, N);
        vecs[7]  = mk(Y, N, Y, Y, N, 20'h00003, 20'h00000, Y, 20'hABCDE, 20'hABCDE, N);
        vecs[8]  = mk(Y, Y, Y, Y, N, 20'h00003, 20'h11111, Y, 20'hABCDE, 20'hABCDE, N);
        vecs[9]  = mk(Y, N, Y, Y, N, 20'h00003, 20'h00000, Y, 20'h11111, 20'h11111, N);
        vecs[10] = mk(N, Y, Y, Y, N, 20'h00003, 20'h22222, N, 20'h00000, 20'h00000, N);
        vecs[11] = mk(Y, N, Y, Y, N, 20'h00003, 20'h00000, Y, 20'h11111, 20'h11111, N);
        vecs[12] = mk(Y, N, Y, N, N, 20'h00025, 20'h00000, Y, 20'h00025, 20'h00025, N);
        vecs[13] = mk(Y, N, Y, Y, N, 20'h00005, 20'h00000, Y, 20'h00005, 20'h00005, N);
        vecs[14] = mk(Y, Y, N, Y, N, 20'h0001E, 20'h12345, N, 20'h00000, 20'h00000, N);
        vecs[15] = mk(Y, N, Y, Y, N, 20'h0001E, 20'h00000, Y, 20'h12345, 20'h00000, N);
        vecs[16] = mk(Y, N, Y, Y, N, 20'hFFFE5, 20'h00000, Y, 20'h00005, 20'h00005, N);
        vecs[17] = mk(Y, Y, N, N, Y, 20'h00009, 20'h00777, Y, 20'h00009, 20'h00009, N);
        vecs[18] = mk(Y, N, Y, Y, N, 20'h00009, 20'h00000, Y, 20'h00777, 20'h00777, PAR_EN);
        vecs[19] = mk(Y, N, Y, Y, N, 20'h0000A, 20'h00000, Y, 20'h0000A, 20'h0000A, N);
        vecs[20] = mk(Y, N, Y, Y, N, 20'h0001F, 20'h00000, Y, 20'h0001F, 20'h00000, N);

        // Reset state
        #3;
        chk("rst_a_ready", req_ready_a, 0);
        chk("rst_b_ready", req_ready_b, 0);
        chk("rst_a_rsp_valid", rsp_valid_a, 0);
        chk("rst_b_rsp_valid", rsp_valid_b, 0);
        chk("rst_a_readData", readData_a, 0);
        chk("rst_b_readData", readData_b, 0);
        chk("rst_a_parity_err", parity_err_a, 0);
        chk("rst_b_parity_err", parity_err_b, 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        measure_init("init1");

        // Main table, back-to-back
        for (int i = 0; i < 21; i++) drive(vecs[i]);
        idle(6);
        chk("hold_a_readData", readData_a, 20'h0001F);
        chk("hold_b_readData", readData_b, 20'h00000);

        // Reset with two reads in flight: dut_a has already returned the first,
        // the second (and both of dut_b's) must never appear.
        drive(mk(Y, N, Y, Y, N, 20'h00001, 20'h0, Y, 20'h00001, 20'h00001, N));
        drive(mk(Y, N, Y, Y, N, 20'h00002, 20'h0, Y, 20'h00002, 20'h00002, N));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        qa.delete();
        qb.delete();
        #2;
        chk("midrst_a_rsp_valid", rsp_valid_a, 0);
        chk("midrst_b_rsp_valid", rsp_valid_b, 0);
        chk("midrst_a_readData", readData_a, 0);
        chk("midrst_b_readData", readData_b, 0);
        chk("midrst_a_ready", req_ready_a, 0);
        chk("midrst_b_ready", req_ready_b, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        measure_init("init2");

        // Array is reinitialised: earlier writes are gone, parity is clean again
        drive(mk(Y, N, Y, Y, N, 20'h00003, 20'h0, Y, 20'h00003, 20'h00003, N));
        drive(mk(Y, N, Y, Y, N, 20'h0001E, 20'h0, Y, 20'h0001E, 20'h00000, N));
        drive(mk(Y, N, Y, Y, N, 20'h00009, 20'h0, Y, 20'h00009, 20'h00009, N));
        drive(mk(Y, N, Y, Y, N, 20'h00004, 20'h0, Y, 20'h00004, 20'h00004, N));
        idle(6);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
